// File: rtl/sram_data_responder.sv
// Responder end of the SRAM-like data interface: word memory behind a small
// in-order response queue with fixed latency and bounded outstanding requests.
module sram_data_responder #(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept_en,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam int unsigned PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned LW    = 4;

    logic [31:0]       mem [DEPTH];
    logic [MEM_AW-1:0] idx;

    logic [QDEPTH-1:0] valid_q, valid_n;
    logic              wr_q    [QDEPTH];
    logic              wr_n    [QDEPTH];
    logic [31:0]       data_q  [QDEPTH];
    logic [31:0]       data_n  [QDEPTH];
    logic [LW-1:0]     cnt_q   [QDEPTH];
    logic [LW-1:0]     cnt_n   [QDEPTH];
    logic [PW-1:0]     head_q, head_n;
    logic [PW-1:0]     tail_q, tail_n;
    logic [CW-1:0]     count_q, count_n;
    logic              data_ok_n;
    logic [31:0]       rdata_n;
    logic              push;
    logic              pop;

    // size and the bits outside the word index carry no function here
    logic unused_ok;
    assign unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign idx     = addr[MEM_AW+1:2];
    assign addr_ok = req & accept_en & ~reset & (count_q < CW'(QDEPTH));
    assign push    = req & addr_ok;
    assign pop     = data_ok;

    // Queue next state; data_ok/rdata are precomputed from it so they leave flops
    always_comb begin
        valid_n = valid_q;
        wr_n    = wr_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        head_n  = head_q;
        tail_n  = tail_q;
        count_n = count_q;

        for (int i = 0; i < int'(QDEPTH); i++) begin
            if (valid_q[i] && (cnt_q[i] != '0)) begin
                cnt_n[i] = cnt_q[i] - LW'(1);
            end
        end

        if (pop) begin
            valid_n[head_q] = 1'b0;
            head_n          = head_q + PW'(1);
        end

        if (push) begin
            valid_n[tail_q] = 1'b1;
            wr_n[tail_q]    = wr;
            data_n[tail_q]  = wr ? 32'h0 : mem[idx];
            cnt_n[tail_q]   = LW'(LATENCY - 1);
            tail_n          = tail_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase

        data_ok_n = valid_n[head_n] && (cnt_n[head_n] == '0);
        rdata_n   = (data_ok_n && !wr_n[head_n]) ? data_n[head_n] : 32'h0;
    end

    // Queue control and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            data_ok <= 1'b0;
            rdata   <= 32'h0;
            rd_cnt  <= 32'h0;
            wr_cnt  <= 32'h0;
        end else begin
            valid_q <= valid_n;
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            data_ok <= data_ok_n;
            rdata   <= rdata_n;
            rd_cnt  <= rd_cnt + 32'(push & ~wr);
            wr_cnt  <= wr_cnt + 32'(push & wr);
        end
    end

    // Entry payload needs no reset: only valid entries are ever observed
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(QDEPTH); i++) begin
            wr_q[i]   <= wr_n[i];
            data_q[i] <= data_n[i];
            cnt_q[i]  <= cnt_n[i];
        end
    end

    // Memory is intentionally not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_data_responder.sv
// Bench for sram_data_responder: cycle table on a LATENCY=2 instance plus
// hand sequences for back-pressure (LATENCY=4) and mid-flight reset (LATENCY=3).
module tb_sram_data_responder;

    logic        clk;
    logic        reset;
    logic        accept_en;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_v     [3];
    logic        addr_ok_v [3];
    logic        data_ok_v [3];
    logic [31:0] rdata_v   [3];
    logic [31:0] rd_cnt_v  [3];
    logic [31:0] wr_cnt_v  [3];

    int n_checks = 0;
    int n_fail   = 0;

    sram_data_responder #(.MEM_AW(12), .LATENCY(2), .QDEPTH(2)) u_l2 (
        .clk(clk), .reset(reset), .accept_en(accept_en), .req(req_v[0]), .wr(wr),
        .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]), .rdata(rdata_v[0]),
        .rd_cnt(rd_cnt_v[0]), .wr_cnt(wr_cnt_v[0]));

    sram_data_responder #(.MEM_AW(12), .LATENCY(4), .QDEPTH(2)) u_l4 (
        .clk(clk), .reset(reset), .accept_en(accept_en), .req(req_v[1]), .wr(wr),
        .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]), .rdata(rdata_v[1]),
        .rd_cnt(rd_cnt_v[1]), .wr_cnt(wr_cnt_v[1]));

    sram_data_responder #(.MEM_AW(12), .LATENCY(3), .QDEPTH(2)) u_l3 (
        .clk(clk), .reset(reset), .accept_en(accept_en), .req(req_v[2]), .wr(wr),
        .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok_v[2]), .data_ok(data_ok_v[2]), .rdata(rdata_v[2]),
        .rd_cnt(rd_cnt_v[2]), .wr_cnt(wr_cnt_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        req;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ok;
        logic        dok;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [32];

    function automatic vec_t mk(input logic en, input logic rq, input logic w,
                                input logic [3:0] s, input logic [31:0] a,
                                input logic [31:0] d, input logic ok,
                                input logic dok, input logic [31:0] rd);
        vec_t r;
        r.en = en; r.req = rq; r.wr = w; r.strb = s; r.addr = a; r.wdata = d;
        r.ok = ok; r.dok = dok; r.rd = rd;
        return r;
    endfunction

    function automatic vec_t idle(input logic dok, input logic [31:0] rd);
        return mk(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, dok, rd);
    endfunction

    function automatic vec_t rd_v(input logic en, input logic [31:0] a, input logic ok,
                                  input logic dok, input logic [31:0] rd);
        return mk(en, 1'b1, 1'b0, 4'h0, a, 32'h0, ok, dok, rd);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one request on instance k until accepted (bounded), returns at a negedge
    task automatic hs(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        bit done;
        done = 1'b0;
        wr = w; addr = a; wdata = d; wstrb = s; req_v[k] = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (addr_ok_v[k]) done = 1'b1;
            @(negedge clk);
        end
        req_v[k] = 1'b0;
        chk("handshake_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [11:0] exp_ok;
        logic [11:0] exp_dok;
        logic [31:0] exp_rd;
        int          nxt;

        reset = 1'b1; accept_en = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'h0;
        addr = 32'h0; wdata = 32'h0;
        for (int k = 0; k < 3; k++) req_v[k] = 1'b0;

        tbl[0]  = mk(1, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF, 1, 0, 0);
        tbl[1]  = idle(0, 0);
        tbl[2]  = idle(1, 0);
        tbl[3]  = rd_v(1, 32'h100, 1, 0, 0);
        tbl[4]  = idle(0, 0);
        tbl[5]  = idle(1, 32'hDEADBEEF);
        tbl[6]  = mk(1, 1, 1, 4'h2, 32'h100, 32'h0000AA00, 1, 0, 0);
        tbl[7]  = rd_v(1, 32'h100, 1, 0, 0);
        tbl[8]  = idle(1, 0);
        tbl[9]  = idle(1, 32'hDEADAAEF);
        tbl[10] = mk(1, 1, 1, 4'hF, 32'h4000, 32'h12345678, 1, 0, 0);
        tbl[11] = rd_v(1, 32'h0, 1, 0, 0);
        tbl[12] = idle(1, 0);
        tbl[13] = idle(1, 32'h12345678);
        for (int i = 14; i <= 18; i++) tbl[i] = rd_v(0, 32'h100, 0, 0, 0);
        tbl[19] = rd_v(1, 32'h100, 1, 0, 0);
        tbl[20] = idle(0, 0);
        tbl[21] = idle(1, 32'hDEADAAEF);
        tbl[22] = mk(1, 1, 1, 4'h0, 32'h100, 32'hFFFFFFFF, 1, 0, 0);
        tbl[23] = rd_v(1, 32'h100, 1, 0, 0);
        tbl[24] = idle(1, 0);
        tbl[25] = idle(1, 32'hDEADAAEF);
        tbl[26] = rd_v(1, 32'h0, 1, 0, 0);
        tbl[27] = rd_v(1, 32'h100, 1, 0, 0);
        tbl[28] = rd_v(1, 32'h0, 0, 1, 32'h12345678);
        tbl[29] = rd_v(1, 32'h0, 1, 1, 32'hDEADAAEF);
        tbl[30] = idle(0, 0);
        tbl[31] = idle(1, 32'h12345678);

        idle_cycles(3);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_addr_ok", 32'(addr_ok_v[k]), 0);
            chk("reset_data_ok", 32'(data_ok_v[k]), 0);
            chk("reset_rdata", rdata_v[k], 0);
            chk("reset_rd_cnt", rd_cnt_v[k], 0);
            chk("reset_wr_cnt", wr_cnt_v[k], 0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Cycle-by-cycle table on the LATENCY=2 instance
        for (int i = 0; i < 32; i++) begin
            accept_en = tbl[i].en; req_v[0] = tbl[i].req; wr = tbl[i].wr;
            wstrb = tbl[i].strb; addr = tbl[i].addr; wdata = tbl[i].wdata;
            #1;
            chk($sformatf("tbl%0d_addr_ok", i), 32'(addr_ok_v[0]), 32'(tbl[i].ok));
            chk($sformatf("tbl%0d_data_ok", i), 32'(data_ok_v[0]), 32'(tbl[i].dok));
            chk($sformatf("tbl%0d_rdata", i), rdata_v[0], tbl[i].rd);
            @(negedge clk);
        end
        req_v[0] = 1'b0; accept_en = 1'b1;
        #1;
        chk("l2_rd_cnt", rd_cnt_v[0], 32'd8);
        chk("l2_wr_cnt", wr_cnt_v[0], 32'd4);
        @(negedge clk);

        // Back-pressure on LATENCY=4, QDEPTH=2 with req held for three reads
        hs(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF);
        hs(1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF);
        hs(1, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF);
        idle_cycles(8);
        exp_ok  = 12'b0000_0010_0011;
        exp_dok = 12'b0010_0011_0000;
        nxt = 0;
        for (int c = 0; c < 12; c++) begin
            req_v[1] = (nxt < 3);
            wr = 1'b0; addr = 32'(nxt * 4);
            #1;
            case (c)
                4:       exp_rd = 32'hA0A0A0A0;
                5:       exp_rd = 32'hB1B1B1B1;
                9:       exp_rd = 32'hC2C2C2C2;
                default: exp_rd = 32'h0;
            endcase
            chk($sformatf("bp_c%0d_addr_ok", c), 32'(addr_ok_v[1]), 32'(exp_ok[c]));
            chk($sformatf("bp_c%0d_data_ok", c), 32'(data_ok_v[1]), 32'(exp_dok[c]));
            chk($sformatf("bp_c%0d_rdata", c), rdata_v[1], exp_rd);
            if (addr_ok_v[1]) nxt++;
            @(negedge clk);
        end
        req_v[1] = 1'b0;
        #1;
        chk("l4_rd_cnt", rd_cnt_v[1], 32'd3);
        chk("l4_wr_cnt", wr_cnt_v[1], 32'd3);
        @(negedge clk);

        // Reset one cycle after an accepted read on LATENCY=3
        hs(2, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF);
        idle_cycles(5);
        wr = 1'b0; addr = 32'h200; req_v[2] = 1'b1;
        #1;
        chk("rst_T_addr_ok", 32'(addr_ok_v[2]), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_T1_addr_ok", 32'(addr_ok_v[2]), 0);
        @(negedge clk);
        reset = 1'b0; req_v[2] = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            chk($sformatf("rst_T%0d_data_ok", c), 32'(data_ok_v[2]), 0);
            chk($sformatf("rst_T%0d_rd_cnt", c), rd_cnt_v[2], 0);
            chk($sformatf("rst_T%0d_wr_cnt", c), wr_cnt_v[2], 0);
            @(negedge clk);
        end
        hs(2, 1'b0, 32'h200, 32'h0, 4'h0);
        nxt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (data_ok_v[2]) begin
                nxt++;
                chk("rst_readback_rdata", rdata_v[2], 32'hCAFEF00D);
            end
            @(negedge clk);
        end
        chk("rst_readback_count", 32'(nxt), 32'd1);
        #1;
        chk("rst_readback_rd_cnt", rd_cnt_v[2], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
